// File: rtl/serial_pkg.sv
// ------------------------------------------------------------------
// serial_pkg : shared widths and state encodings for the serial link
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

  // Upstream parallel-to-serial stage
  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/srl2prl_if.sv
// ------------------------------------------------------------------
// srl2prl_if : serial input, parallel valid/ready output and status
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface srl2prl_if #(
  parameter int DEPTH = 4
);
  import serial_pkg::*;

  logic                   srl;
  logic                   valid;
  logic [BYTE_W-1:0]      prl;
  logic                   prl_valid;
  logic                   prl_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   frame_err;
  logic                   clr;

  modport master (
    output srl, valid, prl_ready, clr,
    input  prl, prl_valid, level, overflow, frame_err
  );

  modport slave (
    input  srl, valid, prl_ready, clr,
    output prl, prl_valid, level, overflow, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO, head word read from storage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when a read frees a slot this cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/srl2prl.sv
// ------------------------------------------------------------------
// srl2prl : MSB-first serial-to-byte receiver with FWFT output FIFO
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module srl2prl
  import serial_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_MAX = 4
) (
  input logic      clock,
  input logic      rst,
  srl2prl_if.slave bus
);

  localparam int GAP_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W-1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_MAX-1);

  rx_state_t            state;
  logic [BYTE_W-1:0]    shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 overflow_q;
  logic                 frame_err_q;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 gap_hit;
  logic [BYTE_W-1:0]    byte_in;

  assign push    = bus.valid && (bit_cnt == LAST_BIT);
  assign byte_in = {shreg[BYTE_W-2:0], bus.srl};
  assign pop     = bus.prl_valid && bus.prl_ready;
  // Gaps only count against a partial byte; idle gaps are free
  assign gap_hit = (state == RX_RECV) && !bus.valid && (gap_cnt == GAP_LAST);

  assign bus.prl_valid = !empty;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .wdata (byte_in),
    .pop   (pop),
    .rdata (bus.prl),
    .level (bus.level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= RX_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (bus.valid) begin
        shreg   <= byte_in;
        gap_cnt <= '0;
        if (push) begin
          bit_cnt <= '0;
          state   <= RX_IDLE;
        end else begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          state   <= RX_RECV;
        end
      end else if (state == RX_RECV) begin
        if (gap_hit) begin
          shreg   <= '0;
          bit_cnt <= '0;
          gap_cnt <= '0;
          state   <= RX_IDLE;
        end else begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
      end

      // A same-cycle set beats clr
      if (push && full && !pop) overflow_q <= 1'b1;
      else if (bus.clr)         overflow_q <= 1'b0;

      if (gap_hit)      frame_err_q <= 1'b1;
      else if (bus.clr) frame_err_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_srl2prl.sv
// ------------------------------------------------------------------
// tb_srl2prl : directed and random stimulus against a queue-based model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_srl2prl;

  localparam int DEPTH   = 4;
  localparam int GAP_MAX = 4;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  always #5 clock = ~clock;

  srl2prl_if #(.DEPTH(DEPTH)) bus ();

  srl2prl #(
    .DEPTH   (DEPTH),
    .GAP_MAX (GAP_MAX)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: byte queue plus the value/length of the partial byte
  logic [7:0] q[$];
  int         m_bits;
  int         m_val;
  int         m_gap;
  logic       m_ovf;
  logic       m_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("prl_valid", 32'(bus.prl_valid), 32'(q.size() != 0));
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
    if (q.size() != 0) chk("prl", 32'(bus.prl), 32'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_bits = 0;
    m_val  = 0;
    m_gap  = 0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic rdy, input logic c);
    logic       pop;
    logic       full;
    logic       got;
    logic       set_ovf;
    logic       set_ferr;
    logic [7:0] nb;
    pop      = (q.size() != 0) && rdy;
    full     = (q.size() == DEPTH);
    got      = 1'b0;
    set_ovf  = 1'b0;
    set_ferr = 1'b0;
    nb       = 8'h00;
    if (v) begin
      m_val = (m_val * 2 + int'(b)) % 256;
      m_bits++;
      m_gap = 0;
      if (m_bits == 8) begin
        got    = 1'b1;
        nb     = 8'(m_val);
        m_bits = 0;
        m_val  = 0;
      end
    end else if (m_bits > 0) begin
      m_gap++;
      if (m_gap == GAP_MAX) begin
        m_bits   = 0;
        m_val    = 0;
        m_gap    = 0;
        set_ferr = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (got) begin
      if (!full || pop) q.push_back(nb);
      else set_ovf = 1'b1;
    end
    m_ovf  = set_ovf  ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_ferr = set_ferr ? 1'b1 : (c ? 1'b0 : m_ferr);
  endtask

  task automatic cyc(input logic v, input logic b, input logic rdy, input logic c);
    bus.valid     = v;
    bus.srl       = b;
    bus.prl_ready = rdy;
    bus.clr       = c;
    @(posedge clock);
    model_step(v, b, rdy, c);
    #1;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++) cyc(1'b1, d[7-i], (i == 7) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_prl", 32'(bus.prl), 32'h0);
    @(posedge clock);
    #1;
    check_all();
    chk("rst_prl_edge", 32'(bus.prl), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    bus.valid     = 1'b0;
    bus.srl       = 1'b0;
    bus.prl_ready = 1'b0;
    bus.clr       = 1'b0;
    model_reset();
    do_reset();

    // Single byte, consumer always ready
    send_byte(8'hA5, 1'b1, 1'b1);
    chk("a5_prl", 32'(bus.prl), 32'hA5);
    chk("a5_valid", 32'(bus.prl_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_gone", 32'(bus.prl_valid), 32'h0);

    // Back-to-back bytes queued, then drained
    send_byte(8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_level", 32'(bus.level), 32'd2);
    chk("b2b_head", 32'(bus.prl), 32'h3C);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_second", 32'(bus.prl), 32'hC3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_drained", 32'(bus.level), 32'd0);

    // Overflow on the fifth byte, then clear
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    chk("ovf_level", 32'(bus.level), 32'd4);
    chk("ovf_head", 32'(bus.prl), 32'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'h0);

    // Full FIFO with a pop on the same edge as the push
    send_byte(8'h77, 1'b0, 1'b1);
    chk("fullpp_level", 32'(bus.level), 32'd4);
    chk("fullpp_ovf", 32'(bus.overflow), 32'h0);
    chk("fullpp_head", 32'(bus.prl), 32'h02);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-byte gap timeout
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_below_max", 32'(bus.frame_err), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_at_max", 32'(bus.frame_err), 32'h1);
    send_byte(8'h81, 1'b0, 1'b0);
    chk("gap_next_byte", 32'(bus.prl), 32'h81);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ferr_clr", 32'(bus.frame_err), 32'h0);

    // Reset in the middle of a byte
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("rst_after_prl", 32'(bus.prl), 32'h5A);
    chk("rst_after_level", 32'(bus.level), 32'd1);

    // Random traffic with occasional long gaps and clears
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/srl2prl.md
# srl2prl

Serial-to-parallel receiver that sits directly downstream of the parallel-to-serial stage. It consumes the MSB-first bit stream (`srl`, `valid`) and reassembles 8-bit bytes. Completed bytes go into a small first-word-fall-through FIFO, which presents them on a valid/ready parallel port. Sticky flags report FIFO overflow and mid-byte stream gaps.

## Interface
- `DEPTH`, 4: FIFO depth in bytes; power of two, 2..16.
- `GAP_MAX`, 4: consecutive `valid`-low cycles tolerated mid-byte before the partial byte is discarded; range 2..15.
- `clock`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `srl`  in  1  serial data bit; sampled only when `valid`=1.
- `valid`  in  1  `srl` carries a data bit this cycle.
- `prl`  out  8  head-of-FIFO byte; meaningful only when `prl_valid`=1.
- `prl_valid`  out  1  FIFO not empty.
- `prl_ready`  in  1  consumer accepts `prl` this cycle.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a completed byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a partial byte was discarded by gap timeout.
- `clr`  in  1  synchronous clear of `overflow` and `frame_err`.

## Operation
- Receive FSM has two states:
  - IDLE: bit count is 0.
  - RECV: 1..7 bits held.
- On each cycle with `valid`=1:
  - `shreg <= {shreg[6:0], srl}`; the first bit received lands in `prl[7]`.
  - Bit count increments.
- On the 8th bit:
  - Byte `{shreg[6:0], srl}` is pushed into the FIFO.
  - Bit count wraps to 0 and the FSM returns to IDLE.
- Gap counter:
  - Counts consecutive `valid`=0 cycles while in RECV.
  - Cleared by any `valid`=1 cycle.
  - On reaching `GAP_MAX`: shreg and bit count clear, FSM goes to IDLE, `frame_err` sets.
  - Gaps in IDLE are unlimited and never flag. The upstream one-cycle inter-byte gap therefore occurs in IDLE and is legal.
- FIFO pop occurs when `prl_valid` & `prl_ready`.
- Push while full without a same-cycle pop: the byte is dropped, `overflow` sets, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both take effect, no overflow, `level` unchanged.
- Push and pop in the same cycle while empty: only the push occurs. `prl_valid` is low that cycle, so no pop is possible.
- `clr` and a same-cycle flag-set event: the set wins and the flag reads 1 next cycle.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. `level` ranges 0..DEPTH.

## Timing
- Reset values: `prl`=8'h00, `prl_valid`=0, `level`=0, `overflow`=0, `frame_err`=0; FSM IDLE, bit count 0, gap count 0, shreg 0.
- Reset asserted mid-byte or with the FIFO non-empty: everything returns to reset values immediately and the partial byte is lost.
- Latency: byte on `prl` with `prl_valid`=1 in the cycle after the edge that samples its 8th bit (1 cycle).
- `prl` and `prl_valid` are registered or driven from FIFO storage; there is no combinational path from `srl` or `valid`.
- Throughput: one byte per 8 `valid` cycles; back-to-back bytes with no gap are accepted.
- `prl_ready` may be held high permanently. If so, each byte is visible for exactly one cycle unless another is queued.
- `frame_err` rises on the edge where the gap count reaches `GAP_MAX`, i.e. visible `GAP_MAX` cycles after the last `valid`=1.

## Structure
- Shared package `serial_pkg`:
  - Localparams `BYTE_W`=8 and `BIT_CNT_W`=3.
  - FSM state encoding `RX_IDLE`=1'b0, `RX_RECV`=1'b1.
  - The upstream serializer's state constants move here too.
- One sub-module, `sync_fifo` (parameters `WIDTH`, `DEPTH`): FWFT storage, pointers, `level`, full/empty.
- The top holds the FSM, shift register, bit/gap counters and sticky flags.

## Test plan
- Reset, then the upstream serializer sends 0xA5 with `prl_ready`=1 -> one cycle after the 8th bit, `prl`=0xA5 and `prl_valid`=1 for exactly one cycle; flags stay 0.
- Back-to-back 0x3C, 0xC3 with the one-cycle gap, `prl_ready`=0 -> `level`=2, `prl`=0x3C. Raising `prl_ready` for 2 cycles yields 0x3C then 0xC3; `level` ends at 0.
- `prl_ready`=0, send 0x01..0x05 with `DEPTH`=4 -> 0x01..0x04 are stored and 0x05 is dropped; `overflow`=1, `level`=4. Pulsing `clr` sets `overflow`=0.
- FIFO full, `prl_ready`=1 in the cycle the 8th bit of 0x77 arrives -> 0x01 popped, 0x77 accepted, `level`=4, `overflow` stays 0.
- Send 3 bits (1,0,1), hold `valid`=0 for 4 cycles, then send 0x81 -> `frame_err`=1 after the 4th idle cycle; next output byte is 0x81.
- Send 5 bits of a byte, assert `rst` for one cycle, release, send 0x5A -> all outputs at reset values during reset; `prl`=0x5A afterwards, `level`=1.
